// File: rtl/seq_detector_fsm_if.sv
//----------------------------------------------------------------------------
// seq_detector_fsm_if : serial bit stream in, detect/progress out. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface seq_detector_fsm_if #(
  parameter int LEN = 4
`ifdef MATCH_COUNT_EN
  , parameter int COUNT_W = 8
`endif
);
  localparam int c_sw = $clog2(LEN + 1);

  logic            clear;
  logic            in_valid;
  logic            in_bit;
  logic            match_mealy;
  logic            match_moore;
  logic [c_sw-1:0] state;

`ifdef MATCH_COUNT_EN
  logic [COUNT_W-1:0] match_count;

  modport master (
    output clear, in_valid, in_bit,
    input  match_mealy, match_moore, state, match_count
  );
  modport slave (
    input  clear, in_valid, in_bit,
    output match_mealy, match_moore, state, match_count
  );
`else
  modport master (
    output clear, in_valid, in_bit,
    input  match_mealy, match_moore, state
  );
  modport slave (
    input  clear, in_valid, in_bit,
    output match_mealy, match_moore, state
  );
`endif
endinterface

`default_nettype wire

// File: rtl/seq_detector_fsm.sv
//----------------------------------------------------------------------------
// seq_detector_fsm : LEN-bit serial pattern detector, Mealy + Moore outputs;
// MATCH_COUNT_EN adds a saturating match counter. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module seq_detector_fsm #(
  parameter int          LEN     = 4,
  parameter logic [15:0] PATTERN = 16'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int          COUNT_W = 8
) (
  input logic               clk,
  input logic               reset,
  seq_detector_fsm_if.slave bus
);
  localparam int              c_sw   = $clog2(LEN + 1);
  localparam logic [LEN-1:0]  c_pat  = PATTERN[LEN-1:0];
  localparam logic [c_sw-1:0] c_full = c_sw'(LEN);

  if (LEN < 2 || LEN > 16 || COUNT_W < 1) begin : g_bad_params
    $error("seq_detector_fsm: LEN must be 2..16 and COUNT_W >= 1");
  end

  logic [c_sw-1:0] state_q, state_d;
  logic [LEN-1:0]  hist_q, hist_d;
  logic [LEN-1:0]  w_mask;
  logic            moore_q;
  logic            w_consume;
  int              w_lim;

  assign w_consume = bus.in_valid & ~bus.clear;
  // Newest bit sits at [0], so the low k bits are the last k bits of the stream.
  assign hist_d    = {hist_q[LEN-2:0], bus.in_bit};

  // Longest suffix (bounded by w_lim) equal to the top k bits of the pattern.
  always_comb begin
    w_mask  = '0;
    state_d = '0;
    if (state_q == c_full) begin
      w_lim = OVERLAP ? LEN : 1;
    end else begin
      w_lim = int'(state_q) + 1;
    end
    for (int k = 1; k <= LEN; k++) begin
      w_mask = ~({LEN{1'b1}} << k);
      if (k <= w_lim && ((hist_d ^ (c_pat >> (LEN - k))) & w_mask) == '0) begin
        state_d = c_sw'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      hist_q  <= '0;
      moore_q <= 1'b0;
    end else if (bus.clear) begin
      state_q <= '0;
      hist_q  <= '0;
      moore_q <= 1'b0;
    end else if (bus.in_valid) begin
      state_q <= state_d;
      hist_q  <= hist_d;
      moore_q <= (state_d == c_full);
    end
  end

  assign bus.match_mealy = reset & w_consume & (state_d == c_full);
  assign bus.match_moore = moore_q;
  assign bus.state       = state_q;

`ifdef MATCH_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (bus.match_mealy && count_q != {COUNT_W{1'b1}}) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.match_count = count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_fsm.sv
//----------------------------------------------------------------------------
// tb_seq_detector_fsm : table-driven + hand-written checks of three detector
// instances (1011 overlap, 1011 non-overlap, 1111 overlap). Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_seq_detector_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detector_fsm_if #(.LEN(4)) ifa ();
  seq_detector_fsm_if #(.LEN(4)) ifb ();
`ifdef MATCH_COUNT_EN
  seq_detector_fsm_if #(.LEN(4), .COUNT_W(2)) ifc ();
`else
  seq_detector_fsm_if #(.LEN(4)) ifc ();
`endif

  seq_detector_fsm #(.LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b1), .COUNT_W(8))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  seq_detector_fsm #(.LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b0), .COUNT_W(8))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  seq_detector_fsm #(.LEN(4), .PATTERN(16'b1111), .OVERLAP(1'b1), .COUNT_W(2))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct {
    bit         rst;
    logic       v, c, b;
    logic [2:0] m;
    int         sa, ma, sb, mb, sc, mc;
  } vec_t;

  vec_t vt[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic b);
    ifa.in_valid = v; ifa.clear = c; ifa.in_bit = b;
    ifb.in_valid = v; ifb.clear = c; ifb.in_bit = b;
    ifc.in_valid = v; ifc.clear = c; ifc.in_bit = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic void add(bit r, logic v, logic c, logic b, logic [2:0] m,
                              int sa, int ma, int sb, int mb, int sc, int mc);
    vt.push_back('{r, v, c, b, m, sa, ma, sb, mb, sc, mc});
  endfunction

  // Expected values queued when driven; popped once the clock edge has produced them.
  task automatic apply(input vec_t t, input int idx);
    vec_t  e;
    string tg;
    tg = $sformatf("vec%0d", idx);
    if (t.rst) do_reset();
    @(negedge clk);
    drive(t.v, t.c, t.b);
    exp_q.push_back(t);
    #2;
    e = exp_q[0];
    if (e.m[0]) chk({tg, " A mealy"}, int'(ifa.match_mealy), e.ma);
    if (e.m[1]) chk({tg, " B mealy"}, int'(ifb.match_mealy), e.mb);
    if (e.m[2]) chk({tg, " C mealy"}, int'(ifc.match_mealy), e.mc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.m[0]) begin
      chk({tg, " A state"}, int'(ifa.state), e.sa);
      chk({tg, " A moore"}, int'(ifa.match_moore), int'(e.sa == 4));
    end
    if (e.m[1]) begin
      chk({tg, " B state"}, int'(ifb.state), e.sb);
      chk({tg, " B moore"}, int'(ifb.match_moore), int'(e.sb == 4));
    end
    if (e.m[2]) begin
      chk({tg, " C state"}, int'(ifc.state), e.sc);
      chk({tg, " C moore"}, int'(ifc.match_moore), int'(e.sc == 4));
    end
  endtask

  // One valid 1-bit into instance C with direct checks after the edge.
  task automatic c_one(input string tg, input int s, input int ml, input int cnt);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1);
    #2;
    chk({tg, " C mealy"}, int'(ifc.match_mealy), ml);
    @(posedge clk);
    #1;
    chk({tg, " C state"}, int'(ifc.state), s);
`ifdef MATCH_COUNT_EN
    chk({tg, " C count"}, int'(ifc.match_count), cnt);
`else
    if (cnt < 0) $display("unreachable");
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low while valid 1s are presented.
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("rst%0d A mealy", i), int'(ifa.match_mealy), 0);
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d A state", i), int'(ifa.state), 0);
      chk($sformatf("rst%0d A moore", i), int'(ifa.match_moore), 0);
      chk($sformatf("rst%0d C state", i), int'(ifc.state), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst release A state", int'(ifa.state), 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);

    // Stream 1011011: overlap (A) vs non-overlap (B).
    add(1, 1, 0, 1, 3'b011, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 3'b011, 2, 0, 2, 0, 0, 0);
    add(0, 1, 0, 1, 3'b011, 3, 0, 3, 0, 0, 0);
    add(0, 1, 0, 1, 3'b011, 4, 1, 4, 1, 0, 0);
    add(0, 1, 0, 0, 3'b011, 2, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 3'b011, 3, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 3'b011, 4, 1, 1, 0, 0, 0);
    // Gaps hold state, clear discards its bit, then a fresh match held over gaps.
    add(1, 1, 0, 1, 3'b011, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 3'b011, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 3'b011, 2, 0, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 3'b011, 2, 0, 2, 0, 0, 0);
    add(0, 1, 0, 1, 3'b011, 3, 0, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 3'b011, 3, 0, 3, 0, 0, 0);
    add(0, 1, 1, 1, 3'b011, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 3'b011, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 3'b011, 2, 0, 2, 0, 0, 0);
    add(0, 1, 0, 1, 3'b011, 3, 0, 3, 0, 0, 0);
    add(0, 1, 0, 1, 3'b011, 4, 1, 4, 1, 0, 0);
    add(0, 0, 0, 0, 3'b011, 4, 0, 4, 0, 0, 0);
    add(0, 0, 0, 1, 3'b011, 4, 0, 4, 0, 0, 0);
    // Six 1s into the 1111 detector: back-to-back matches.
    add(1, 1, 0, 1, 3'b100, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 3'b100, 0, 0, 0, 0, 2, 0);
    add(0, 1, 0, 1, 3'b100, 0, 0, 0, 0, 3, 0);
    add(0, 1, 0, 1, 3'b100, 0, 0, 0, 0, 4, 1);
    add(0, 1, 0, 1, 3'b100, 0, 0, 0, 0, 4, 1);
    add(0, 1, 0, 1, 3'b100, 0, 0, 0, 0, 4, 1);

    foreach (vt[i]) apply(vt[i], i);

    // Counter saturation (COUNT_W=2) and asynchronous reset mid-stream.
    do_reset();
    c_one("sat1", 1, 0, 0);
    c_one("sat2", 2, 0, 0);
    c_one("sat3", 3, 0, 0);
    c_one("sat4", 4, 1, 1);
    c_one("sat5", 4, 1, 2);
    c_one("sat6", 4, 1, 3);
    c_one("sat7", 4, 1, 3);
    c_one("sat8", 4, 1, 3);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async C state", int'(ifc.state), 0);
    chk("async C moore", int'(ifc.match_moore), 0);
    chk("async C mealy", int'(ifc.match_mealy), 0);
`ifdef MATCH_COUNT_EN
    chk("async C count", int'(ifc.match_count), 0);
`endif
    #1;
    reset = 1'b1;
    c_one("post1", 1, 0, 0);
    c_one("post2", 2, 0, 0);
    c_one("post3", 3, 0, 0);
    c_one("post4", 4, 1, 1);

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
